// File: rtl/cdb_pkg.sv
// -----------------------------------------------------------------------------
// cdb_pkg
// Shared definitions for the common data bus (CDB) result-return path.
// Holds the default widths, the functional-unit count derivation and the
// broadcast record that the ROB and register-file snoopers decode.
//
// Contents:
//   CDB_DATA_WIDTH  default result width
//   CDB_TAG_WIDTH   default ROB tag width
//   CDB_EXEC_WIDTH  default functional-unit ID width
//   CDB_NUM_FU      number of functional-unit slots (2**CDB_EXEC_WIDTH)
//   cdb_t           packed {valid, tag, data, executionID} broadcast record
//   cdbNumFu()      slot count for a given ID width
// -----------------------------------------------------------------------------
package cdb_pkg;

  localparam int CDB_DATA_WIDTH = 32;
  localparam int CDB_TAG_WIDTH  = 7;
  localparam int CDB_EXEC_WIDTH = 4;
  localparam int CDB_NUM_FU     = 2 ** CDB_EXEC_WIDTH;

  typedef struct packed {
    logic                      valid;
    logic [CDB_TAG_WIDTH-1:0]  tag;
    logic [CDB_DATA_WIDTH-1:0] data;
    logic [CDB_EXEC_WIDTH-1:0] executionID;
  } cdb_t;

  // Every functional-unit ID value names exactly one slot.
  function automatic int cdbNumFu(input int execWidth);
    return 2 ** execWidth;
  endfunction

endpackage

// File: rtl/rr_arbiter.sv
// -----------------------------------------------------------------------------
// rr_arbiter
// Combinational round-robin arbiter. Grants the first requesting index at or
// after the pointer, wrapping around. The request vector width is 2**IDX_W so
// index arithmetic wraps naturally. Shared with the dispatch unit.
//
// Ports:
//   req_i       in   N      request vector
//   ptr_i       in   IDX_W  highest-priority index this cycle
//   grant_o     out  N      one-hot grant (all zero when nothing requests)
//   grantIdx_o  out  IDX_W  encoded index of the granted request
//   anyGrant_o  out  1      some request was granted
// -----------------------------------------------------------------------------
module rr_arbiter #(
  parameter  int IDX_W = 4,
  localparam int N     = 2 ** IDX_W
) (
  input  logic [N-1:0]     req_i,
  input  logic [IDX_W-1:0] ptr_i,
  output logic [N-1:0]     grant_o,
  output logic [IDX_W-1:0] grantIdx_o,
  output logic             anyGrant_o
);

  // Walk the requests in priority order starting at the pointer; the first
  // one found wins and later hits are ignored.
  always_comb begin
    logic [IDX_W-1:0] idx;
    grant_o    = '0;
    grantIdx_o = '0;
    anyGrant_o = 1'b0;
    idx        = '0;
    for (int k = 0; k < N; k++) begin
      idx = ptr_i + IDX_W'(k);
      if (!anyGrant_o && req_i[idx]) begin
        grant_o[idx] = 1'b1;
        grantIdx_o   = idx;
        anyGrant_o   = 1'b1;
      end
    end
  end

endmodule

// File: rtl/completion_bus.sv
// -----------------------------------------------------------------------------
// completion_bus
// Result-return path from the functional units to the ROB and register file.
// Each functional unit deposits a finished (tag, data) into a one-entry slot;
// a round-robin arbiter picks one held slot per cycle and broadcasts it on a
// registered common data bus.
//
// Optional feature macro: COMPLETION_BUS_EXCEPTION_EN
//   When defined, each slot also stores an exception bit (fu_exception) that
//   is broadcast alongside the result on cdb_exception.
//
// Ports:
//   clk              in   1                    clock, rising edge
//   rst              in   1                    asynchronous active-high reset
//   halt             in   1                    freeze: no capture, no grant
//   flush            in   1                    discard held and in-flight results
//   fu_valid         in   NUM_FU               result present from FU i
//   fu_ready         out  NUM_FU               slot i can accept
//   fu_tag           in   NUM_FU*TAG_WIDTH     packed tags, FU i at [i*TAG_WIDTH +: TAG_WIDTH]
//   fu_data          in   NUM_FU*DATA_WIDTH    packed results, same packing
//   cdb_valid        out  1                    broadcast valid (one-cycle pulse)
//   cdb_tag          out  TAG_WIDTH            broadcast tag
//   cdb_data         out  DATA_WIDTH           broadcast value
//   cdb_executionID  out  EXEC_WIDTH           source functional-unit index
//   fu_exception     in   NUM_FU               (feature only) exception bit per FU
//   cdb_exception    out  1                    (feature only) broadcast exception
// -----------------------------------------------------------------------------
module completion_bus
  import cdb_pkg::*;
#(
  parameter  int DATA_WIDTH = CDB_DATA_WIDTH,
  parameter  int TAG_WIDTH  = CDB_TAG_WIDTH,
  parameter  int EXEC_WIDTH = CDB_EXEC_WIDTH,
  localparam int NUM_FU     = cdbNumFu(EXEC_WIDTH)
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         halt,
  input  logic                         flush,
  input  logic [NUM_FU-1:0]            fu_valid,
  output logic [NUM_FU-1:0]            fu_ready,
  input  logic [NUM_FU*TAG_WIDTH-1:0]  fu_tag,
  input  logic [NUM_FU*DATA_WIDTH-1:0] fu_data,
  output logic                         cdb_valid,
  output logic [TAG_WIDTH-1:0]         cdb_tag,
  output logic [DATA_WIDTH-1:0]        cdb_data,
  output logic [EXEC_WIDTH-1:0]        cdb_executionID
`ifdef COMPLETION_BUS_EXCEPTION_EN
  ,
  input  logic [NUM_FU-1:0]            fu_exception,
  output logic                         cdb_exception
`endif
);

  logic                  active;
  logic [NUM_FU-1:0]     held_q, held_d;
  logic [NUM_FU-1:0]     req, grant, capture;
  logic [EXEC_WIDTH-1:0] grantIdx;
  logic                  anyGrant;
  logic [EXEC_WIDTH-1:0] ptr_q, ptr_d;

  logic [TAG_WIDTH-1:0]  slotTag_q  [NUM_FU];
  logic [DATA_WIDTH-1:0] slotData_q [NUM_FU];

  logic                  cdbValid_q;
  logic [TAG_WIDTH-1:0]  cdbTag_q;
  logic [DATA_WIDTH-1:0] cdbData_q;
  logic [EXEC_WIDTH-1:0] cdbExec_q;

  // Halt and flush both suppress all movement through the slots.
  assign active = !halt && !flush;

  // Gating requests here keeps every grant, and therefore fu_ready's bypass
  // term, silent during halt/flush. fu_ready never looks at fu_valid.
  assign req      = held_q & {NUM_FU{active}};
  assign fu_ready = {NUM_FU{active}} & (~held_q | grant);
  assign capture  = fu_valid & fu_ready;

  rr_arbiter #(
    .IDX_W(EXEC_WIDTH)
  ) uArbiter (
    .req_i     (req),
    .ptr_i     (ptr_q),
    .grant_o   (grant),
    .grantIdx_o(grantIdx),
    .anyGrant_o(anyGrant)
  );

  // A granted slot empties unless it is refilled on the same edge; flush
  // empties everything. Under halt neither grant nor capture can occur, so
  // held_q is naturally frozen. The pointer only moves past a winner.
  always_comb begin
    held_d = (held_q & ~grant) | capture;
    ptr_d  = ptr_q;
    if (flush) begin
      held_d = '0;
    end
    if (anyGrant) begin
      ptr_d = grantIdx + EXEC_WIDTH'(1);
    end
  end

  // Slot payload registers: written only on capture, otherwise preserved
  // (including across halt and flush).
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < NUM_FU; i++) begin
        slotTag_q[i]  <= '0;
        slotData_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (capture[i]) begin
          slotTag_q[i]  <= fu_tag[i*TAG_WIDTH +: TAG_WIDTH];
          slotData_q[i] <= fu_data[i*DATA_WIDTH +: DATA_WIDTH];
        end
      end
    end
  end

  // Occupancy, arbitration pointer and the registered broadcast. The payload
  // fields of the bus keep their last values when nothing is granted.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      held_q     <= '0;
      ptr_q      <= '0;
      cdbValid_q <= 1'b0;
      cdbTag_q   <= '0;
      cdbData_q  <= '0;
      cdbExec_q  <= '0;
    end else begin
      held_q     <= held_d;
      ptr_q      <= ptr_d;
      cdbValid_q <= anyGrant;
      if (anyGrant) begin
        cdbTag_q  <= slotTag_q[grantIdx];
        cdbData_q <= slotData_q[grantIdx];
        cdbExec_q <= grantIdx;
      end
    end
  end

  assign cdb_valid       = cdbValid_q;
  assign cdb_tag         = cdbTag_q;
  assign cdb_data        = cdbData_q;
  assign cdb_executionID = cdbExec_q;

`ifdef COMPLETION_BUS_EXCEPTION_EN
  logic [NUM_FU-1:0] slotExc_q;
  logic              cdbExc_q;

  // The exception bit travels with its result; on the bus it drops together
  // with cdb_valid rather than holding like the payload fields.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      slotExc_q <= '0;
      cdbExc_q  <= 1'b0;
    end else begin
      for (int i = 0; i < NUM_FU; i++) begin
        if (capture[i]) begin
          slotExc_q[i] <= fu_exception[i];
        end
      end
      cdbExc_q <= anyGrant ? slotExc_q[grantIdx] : 1'b0;
    end
  end

  assign cdb_exception = cdbExc_q;
`endif

endmodule

// File: doc/completion_bus.md
# completion_bus

Result-return path from the functional units back to the reorder buffer and register file; the return end of the dispatch interface. Each functional unit hands a finished result (tag, data) to a one-entry holding slot. A round-robin arbiter picks one held result per cycle and broadcasts it on a registered common data bus (CDB). The ROB marks the tag complete and the register file and waiting entries snoop the value.

## Interface
Parameters:
- DATA_WIDTH, 32, result width
- TAG_WIDTH, 7, ROB tag width
- EXEC_WIDTH, 4, functional-unit ID width; NUM_FU = 2**EXEC_WIDTH slots

Ports:
- clk  in  1  single clock, rising edge
- rst  in  1  reset, asynchronous, active-high
- halt  in  1  freeze: no capture, no grant
- flush  in  1  discard all held and in-flight results
- fu_valid  in  NUM_FU  result present from FU i
- fu_ready  out  NUM_FU  slot i can accept
- fu_tag  in  NUM_FU*TAG_WIDTH  packed tags, FU i at [i*TAG_WIDTH +: TAG_WIDTH]
- fu_data  in  NUM_FU*DATA_WIDTH  packed results, same packing
- cdb_valid  out  1  broadcast valid
- cdb_tag  out  TAG_WIDTH  broadcast tag
- cdb_data  out  DATA_WIDTH  broadcast value
- cdb_executionID  out  EXEC_WIDTH  index of the source FU

## Operation
- Per slot i: held[i], tag, data registers.
- fu_ready[i] = !halt && !flush && (!held[i] || grant[i]).
- Capture at an edge when fu_valid[i] && fu_ready[i]; held[i] is set.
- Grant is combinational. It is a round-robin over held[] starting at pointer ptr: the first held index at or after ptr, with wrap-around. No grant while halt or flush is high.
- On a grant to index g: at the edge, cdb_* is loaded from slot g, cdb_executionID = g, and ptr = (g+1) mod NUM_FU. held[g] clears unless it is recaptured in the same edge (ready bypass). A simultaneous grant and capture on the same slot is legal and keeps the slot full.
- With no grant, cdb_valid = 0 next cycle. cdb_tag, cdb_data and cdb_executionID hold their last values.
- flush: at the edge, all held[] and cdb_valid clear. ptr is unchanged. Flush beats a simultaneous capture and grant.
- halt: held[] and ptr are frozen and cdb_valid = 0 next cycle. Slot contents are preserved.
- Reset values: held = 0, ptr = 0, cdb_valid = 0, cdb_tag = 0, cdb_data = 0, cdb_executionID = 0. fu_ready is all ones after reset.

## Timing
- Minimum latency: fu_valid sampled at edge k, then cdb_valid high in the cycle after edge k+1 (2 cycles).
- Throughput: one broadcast per cycle.
- Starvation bound: a held result is broadcast within NUM_FU grant cycles.
- cdb_valid is a one-cycle pulse per result. There is no backpressure from the consumers.
- fu_ready depends combinationally on halt and flush; there is no combinational path from fu_valid to fu_ready.

## Configuration
- COMPLETION_BUS_EXCEPTION_EN defined:
  - adds fu_exception (in, NUM_FU) and cdb_exception (out, 1).
  - Each slot stores the bit, and it is broadcast with the result.
  - cdb_exception resets to 0 and clears with cdb_valid.
- Undefined: neither port exists and no exception storage is built.

## Structure
- Shared package cdb_pkg holds:
  - width parameters
  - the NUM_FU derivation
  - a packed cdb_t struct {valid, tag, data, executionID}, used by the ROB and register file snoopers.
- Sub-module rr_arbiter (request vector and pointer in; one-hot grant, encoded index and any-grant out). It is reusable by the dispatch unit.

## Test plan
- Reset, then FU 3 result tag 0x15 data 0xDEADBEEF → cdb_valid high for exactly one cycle, 2 cycles after fu_valid, with tag 0x15, data 0xDEADBEEF, executionID 3.
- FUs 0, 1 and 5 valid in the same cycle with ptr = 0 → broadcasts in order 0, 1, 5 on consecutive cycles; fu_ready low for slots 1 and 5 while held.
- FU 2 streams a new result every cycle with FU 7 also continuously valid → both alternate, each broadcast at least every 2 cycles, with no lost or duplicated tags.
- Slots 4 and 9 held, flush pulsed for one cycle → no broadcast for either; cdb_valid 0 next cycle; fu_ready all ones after.
- Slot 6 held, halt held for 5 cycles → no cdb_valid and fu_ready all 0 during halt; slot 6 broadcasts 1 cycle after halt drops.
- Reset asserted mid-stream with cdb_valid high → all outputs go to 0 immediately (asynchronous), with no broadcast after release.
